// File: rtl/shape_seq.sv
// ---------------------------------------------------------------------------
// shape_seq
//
// Purpose:
//   Walks a vertex list held in an external synchronous ROM, passes each
//   vertex through an external rotator, translates the rotated point by a
//   latched position and emits line segments between consecutive pen-down
//   vertices to a downstream line drawer over a valid/ready handshake.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a shape (sampled in IDLE only)
//   base_addr  in   first vertex address
//   pos_x/y    in   signed translation applied to every rotated vertex
//   theta      in   rotation angle handed to the rotator
//   busy       out  high in every state except IDLE
//   done       out  one-cycle pulse when a shape completes
//   rom_addr   out  vertex ROM address (ROM answers one cycle later)
//   rom_data   in   {end, pen, vx, vy}
//   rot_x/y    out  sign-extended vertex coordinates to the rotator
//   rot_theta  out  latched angle to the rotator
//   rot_rx/ry  in   rotated point, ROT_LAT cycles after rot_x/rot_y
//   seg_valid  out  segment available
//   seg_ready  in   downstream accepts the segment
//   seg_x0..y1 out  segment endpoints (prev -> cur)
// ---------------------------------------------------------------------------
module shape_seq #(
    parameter int DATA_W  = 18,
    parameter int PHASE_W = 10,
    parameter int VTX_W   = 8,
    parameter int ADDR_W  = 8,
    parameter int ROT_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [DATA_W-1:0]    pos_x,
    input  logic [DATA_W-1:0]    pos_y,
    input  logic [PHASE_W-1:0]   theta,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [2*VTX_W+1:0]   rom_data,
    output logic [DATA_W-1:0]    rot_x,
    output logic [DATA_W-1:0]    rot_y,
    output logic [PHASE_W-1:0]   rot_theta,
    input  logic [DATA_W-1:0]    rot_rx,
    input  logic [DATA_W-1:0]    rot_ry,
    output logic                 seg_valid,
    input  logic                 seg_ready,
    output logic [DATA_W-1:0]    seg_x0,
    output logic [DATA_W-1:0]    seg_y0,
    output logic [DATA_W-1:0]    seg_x1,
    output logic [DATA_W-1:0]    seg_y1
);

    localparam int RCNT_W = (ROT_LAT < 1) ? 1 : $clog2(ROT_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_ROT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [1:0]          r_rstPipe;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_vtxCnt;
    logic [DATA_W-1:0]   r_posX;
    logic [DATA_W-1:0]   r_posY;
    logic [PHASE_W-1:0]  r_rotTheta;
    logic [DATA_W-1:0]   r_rotX;
    logic [DATA_W-1:0]   r_rotY;
    logic                r_vtxEnd;
    logic                r_vtxPen;
    logic                r_first;
    logic [RCNT_W-1:0]   r_rotCnt;
    logic [DATA_W-1:0]   r_prevX;
    logic [DATA_W-1:0]   r_prevY;
    logic                r_segValid;
    logic [DATA_W-1:0]   r_segX0;
    logic [DATA_W-1:0]   r_segY0;
    logic [DATA_W-1:0]   r_segX1;
    logic [DATA_W-1:0]   r_segY1;
    logic                r_busy;
    logic                r_done;

    logic                w_runEn;
    logic signed [VTX_W-1:0] w_romVx;
    logic signed [VTX_W-1:0] w_romVy;
    logic [DATA_W-1:0]   w_curX;
    logic [DATA_W-1:0]   w_curY;
    logic                w_lastVtx;
    logic                w_rotLast;

    // Vertex fields; the signed view lets a size cast sign-extend them.
    assign w_romVx = rom_data[2*VTX_W-1:VTX_W];
    assign w_romVy = rom_data[VTX_W-1:0];

    // Translated point; plain DATA_W addition wraps on overflow.
    assign w_curX = rot_rx + r_posX;
    assign w_curY = rot_ry + r_posY;

    // A vertex ends the shape when it carries the end flag or when it is the
    // 2^ADDR_W-th vertex visited (guards against a list with no terminator).
    assign w_lastVtx = r_vtxEnd || (r_vtxCnt == {ADDR_W{1'b1}});
    assign w_rotLast = (r_rotCnt == RCNT_W'(ROT_LAT));

    assign busy      = r_busy;
    assign done      = r_done;
    assign rom_addr  = r_addr;
    assign rot_x     = r_rotX;
    assign rot_y     = r_rotY;
    assign rot_theta = r_rotTheta;
    assign seg_valid = r_segValid;
    assign seg_x0    = r_segX0;
    assign seg_y0    = r_segY0;
    assign seg_x1    = r_segX1;
    assign seg_y1    = r_segY1;

    // Reset release synchroniser: assertion is immediate, but the sequencer
    // stays parked in IDLE until two clean edges have passed after release,
    // so the first edge it acts on never races the rst_n deassertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstPipe <= 2'b00;
        end else begin
            r_rstPipe <= {r_rstPipe[0], 1'b1};
        end
    end

    assign w_runEn = r_rstPipe[1];

    // Main sequencer. One vertex costs FETCH + LOAD + (ROT_LAT+1) ROT cycles,
    // plus one EMIT cycle when a segment is drawn and accepted at once.
    // All outputs are registered here so downstream sees glitch-free values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_vtxCnt   <= '0;
            r_posX     <= '0;
            r_posY     <= '0;
            r_rotTheta <= '0;
            r_rotX     <= '0;
            r_rotY     <= '0;
            r_vtxEnd   <= 1'b0;
            r_vtxPen   <= 1'b0;
            r_first    <= 1'b1;
            r_rotCnt   <= '0;
            r_prevX    <= '0;
            r_prevY    <= '0;
            r_segValid <= 1'b0;
            r_segX0    <= '0;
            r_segY0    <= '0;
            r_segX1    <= '0;
            r_segY1    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (w_runEn) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr     <= base_addr;
                        r_posX     <= pos_x;
                        r_posY     <= pos_y;
                        r_rotTheta <= theta;
                        r_first    <= 1'b1;
                        r_vtxCnt   <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end

                // rom_addr already holds the vertex address; the ROM
                // samples it on the edge that leaves this state.
                S_FETCH: begin
                    r_state <= S_LOAD;
                end

                S_LOAD: begin
                    r_vtxEnd <= rom_data[2*VTX_W+1];
                    r_vtxPen <= rom_data[2*VTX_W];
                    r_rotX   <= DATA_W'(w_romVx);
                    r_rotY   <= DATA_W'(w_romVy);
                    r_rotCnt <= '0;
                    r_state  <= S_ROT;
                end

                // rot_x/rot_y stay put while the rotator works; its result is
                // valid in the final count, where the vertex is committed.
                S_ROT: begin
                    if (w_rotLast) begin
                        r_rotCnt <= '0;
                        r_prevX  <= w_curX;
                        r_prevY  <= w_curY;
                        r_first  <= 1'b0;
                        if (r_vtxPen && !r_first) begin
                            r_segX0    <= r_prevX;
                            r_segY0    <= r_prevY;
                            r_segX1    <= w_curX;
                            r_segY1    <= w_curY;
                            r_segValid <= 1'b1;
                            r_state    <= S_EMIT;
                        end else if (w_lastVtx) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_addr   <= r_addr + ADDR_W'(1);
                            r_vtxCnt <= r_vtxCnt + ADDR_W'(1);
                            r_state  <= S_FETCH;
                        end
                    end else begin
                        r_rotCnt <= r_rotCnt + RCNT_W'(1);
                    end
                end

                // Segment registers are only written in ROT, so they hold
                // steady for as long as the drawer stalls.
                S_EMIT: begin
                    if (seg_ready) begin
                        r_segValid <= 1'b0;
                        if (w_lastVtx) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_addr   <= r_addr + ADDR_W'(1);
                            r_vtxCnt <= r_vtxCnt + ADDR_W'(1);
                            r_state  <= S_FETCH;
                        end
                    end
                end

                // busy drops on the same edge the state returns to IDLE.
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shape_seq.sv
// ---------------------------------------------------------------------------
// tb_shape_seq
//
// Drives shape_seq with a behavioural ROM and an identity rotator of
// latency one. A list-walking model derives the expected segment stream
// from the ROM contents; every cycle the segment outputs are compared
// against the head of that list, and hand-computed literals pin the model
// and the cycle counts of each shape.
// ---------------------------------------------------------------------------
module tb_shape_seq;

    localparam int DATA_W  = 18;
    localparam int PHASE_W = 10;
    localparam int VTX_W   = 8;
    localparam int ADDR_W  = 4;
    localparam int ROT_LAT = 1;
    localparam int ROM_W   = 2*VTX_W+2;
    localparam int ROM_N   = 1 << ADDR_W;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [DATA_W-1:0]   pos_x;
    logic [DATA_W-1:0]   pos_y;
    logic [PHASE_W-1:0]  theta;
    logic                busy;
    logic                done;
    logic [ADDR_W-1:0]   rom_addr;
    logic [ROM_W-1:0]    rom_data;
    logic [DATA_W-1:0]   rot_x;
    logic [DATA_W-1:0]   rot_y;
    logic [PHASE_W-1:0]  rot_theta;
    logic [DATA_W-1:0]   rot_rx;
    logic [DATA_W-1:0]   rot_ry;
    logic                seg_valid;
    logic                seg_ready;
    logic [DATA_W-1:0]   seg_x0;
    logic [DATA_W-1:0]   seg_y0;
    logic [DATA_W-1:0]   seg_x1;
    logic [DATA_W-1:0]   seg_y1;

    typedef struct {
        int x0;
        int y0;
        int x1;
        int y1;
    } seg_t;

    logic [ROM_W-1:0] rom [ROM_N];
    seg_t expQ[$];

    int nCompared;
    int nFailed;
    int xferCnt;
    int doneCnt;
    int busyCnt;
    bit prevValid;
    bit prevDone;

    shape_seq #(
        .DATA_W  (DATA_W),
        .PHASE_W (PHASE_W),
        .VTX_W   (VTX_W),
        .ADDR_W  (ADDR_W),
        .ROT_LAT (ROT_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .theta     (theta),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rot_x     (rot_x),
        .rot_y     (rot_y),
        .rot_theta (rot_theta),
        .rot_rx    (rot_rx),
        .rot_ry    (rot_ry),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .seg_x0    (seg_x0),
        .seg_y0    (seg_y0),
        .seg_x1    (seg_x1),
        .seg_y1    (seg_y1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM with a one-cycle read.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Identity rotator with one cycle of latency.
    always @(posedge clk) begin
        rot_rx <= rot_x;
        rot_ry <= rot_y;
    end

    function automatic int wrapD(input int v);
        logic [DATA_W-1:0] t;
        t = v[DATA_W-1:0];
        return int'($signed(t));
    endfunction

    function automatic void setVtx(input int idx, input int vx, input int vy,
                                   input bit pen, input bit endF);
        rom[idx] = {endF, pen, VTX_W'(vx), VTX_W'(vy)};
    endfunction

    function automatic void clearRom();
        for (int i = 0; i < ROM_N; i++) rom[i] = '0;
    endfunction

    function automatic void loadSquare();
        clearRom();
        setVtx(0, 0, 0, 1'b0, 1'b0);
        setVtx(1, 10, 0, 1'b1, 1'b0);
        setVtx(2, 10, 10, 1'b1, 1'b0);
        setVtx(3, 0, 10, 1'b1, 1'b0);
        setVtx(4, 0, 0, 1'b1, 1'b1);
    endfunction

    // Walks the vertex list the way a plotter would: pen-down moves after
    // the first vertex become segments; stop on end or after ROM_N vertices.
    function automatic void buildExpected(input int base, input int px, input int py);
        int addr;
        bit first;
        int prevX;
        int prevY;
        int cx;
        int cy;
        logic [ROM_W-1:0] w;
        expQ.delete();
        addr  = base;
        first = 1'b1;
        prevX = 0;
        prevY = 0;
        for (int n = 0; n < ROM_N; n++) begin
            w  = rom[addr];
            cx = wrapD(int'($signed(w[2*VTX_W-1:VTX_W])) + px);
            cy = wrapD(int'($signed(w[VTX_W-1:0])) + py);
            if (w[2*VTX_W] && !first) expQ.push_back('{prevX, prevY, cx, cy});
            prevX = cx;
            prevY = cy;
            first = 1'b0;
            if (w[ROM_W-1]) break;
            addr = (addr + 1) % ROM_N;
        end
    endfunction

    task automatic checkOutput(input string name, input int got, input int want);
        nCompared++;
        if (got != want) begin
            nFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Per-cycle comparison of the DUT against the expected segment stream,
    // taken 1 time unit after each rising edge.
    task automatic monitorStep();
        seg_t e;
        int gx0, gy0, gx1, gy1;
        if (!rst_n) begin
            prevValid = 1'b0;
            prevDone  = 1'b0;
            return;
        end
        if (prevValid && seg_ready) begin
            if (expQ.size() > 0) void'(expQ.pop_front());
            xferCnt++;
        end
        if (seg_valid) begin
            nCompared++;
            gx0 = int'($signed(seg_x0));
            gy0 = int'($signed(seg_y0));
            gx1 = int'($signed(seg_x1));
            gy1 = int'($signed(seg_y1));
            if (expQ.size() == 0) begin
                nFailed++;
                $display("[TB] FAIL seg_unexpected: got (%0d,%0d)-(%0d,%0d), expected no segment",
                         gx0, gy0, gx1, gy1);
            end else begin
                e = expQ[0];
                if (gx0 != e.x0 || gy0 != e.y0 || gx1 != e.x1 || gy1 != e.y1) begin
                    nFailed++;
                    $display("[TB] FAIL seg_value: got (%0d,%0d)-(%0d,%0d), expected (%0d,%0d)-(%0d,%0d)",
                             gx0, gy0, gx1, gy1, e.x0, e.y0, e.x1, e.y1);
                end
            end
        end
        if (busy) busyCnt++;
        if (done) begin
            doneCnt++;
            checkOutput("done_width", int'(prevDone), 0);
            checkOutput("segs_left_at_done", expQ.size(), 0);
        end
        prevValid = seg_valid;
        prevDone  = done;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        monitorStep();
    endtask

    // Launches a shape, then scrambles the inputs that must have been latched.
    task automatic applyStimulus(input int base, input int px, input int py, input int th);
        xferCnt   = 0;
        doneCnt   = 0;
        busyCnt   = 0;
        base_addr = ADDR_W'(base);
        pos_x     = DATA_W'(px);
        pos_y     = DATA_W'(py);
        theta     = PHASE_W'(th);
        start     = 1'b1;
        cycle();
        start     = 1'b0;
        checkOutput("busy_at_start", int'(busy), 1);
        base_addr = ~base_addr;
        pos_x     = pos_x + DATA_W'(1234);
        pos_y     = pos_y - DATA_W'(77);
        theta     = theta + PHASE_W'(1);
    endtask

    task automatic waitDone(input int budget, input bit pulseStart);
        int n;
        n = 0;
        while (doneCnt == 0 && n < budget) begin
            if (pulseStart && (n % 10) == 5) begin
                start     = 1'b1;
                base_addr = '0;
                pos_x     = '0;
            end
            cycle();
            start = 1'b0;
            n++;
        end
        checkOutput("done_seen", doneCnt, 1);
        cycle();
        checkOutput("busy_after_done", int'(busy), 0);
        cycle();
        cycle();
        checkOutput("done_once", doneCnt, 1);
    endtask

    task automatic waitSegValid(input int budget);
        int n;
        n = 0;
        while (!seg_valid && n < budget) begin
            cycle();
            n++;
        end
        checkOutput("emit_reached", int'(seg_valid), 1);
    endtask

    initial begin
        int cnt;
        nCompared = 0;
        nFailed   = 0;
        xferCnt   = 0;
        doneCnt   = 0;
        busyCnt   = 0;
        prevValid = 1'b0;
        prevDone  = 1'b0;
        rst_n     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        pos_x     = '0;
        pos_y     = '0;
        theta     = '0;
        seg_ready = 1'b1;
        clearRom();

        // Reset values
        #3 rst_n = 1'b0;
        cycle();
        cycle();
        cycle();
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_seg_valid", int'(seg_valid), 0);
        checkOutput("rst_rom_addr", int'(rom_addr), 0);
        checkOutput("rst_seg_or", int'(|{seg_x0, seg_y0, seg_x1, seg_y1}), 0);
        checkOutput("rst_rot_or", int'(|{rot_x, rot_y, rot_theta}), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        $display("[TB] reset released");

        // Square at (100,50)
        loadSquare();
        buildExpected(0, 100, 50);
        checkOutput("model_sq_nseg", expQ.size(), 4);
        checkOutput("model_sq_seg0_x1", expQ[0].x1, 110);
        checkOutput("model_sq_seg2_x0", expQ[2].x0, 110);
        checkOutput("model_sq_seg3_y1", expQ[3].y1, 50);
        applyStimulus(0, 100, 50, 0);
        waitDone(200, 1'b0);
        checkOutput("sq_xfers", xferCnt, 4);
        checkOutput("sq_busy_cycles", busyCnt, 25);

        // Square with the first segment stalled for 7 cycles
        buildExpected(0, 100, 50);
        seg_ready = 1'b0;
        applyStimulus(0, 100, 50, 0);
        waitSegValid(40);
        for (int i = 0; i < 7; i++) cycle();
        seg_ready = 1'b1;
        waitDone(200, 1'b0);
        checkOutput("bp_xfers", xferCnt, 4);
        checkOutput("bp_busy_cycles", busyCnt, 32);

        // Pen up on the third vertex
        setVtx(2, 10, 10, 1'b0, 1'b0);
        buildExpected(0, 100, 50);
        cnt = 0;
        foreach (expQ[i]) if (expQ[i].x1 == 110 && expQ[i].y1 == 60) cnt++;
        checkOutput("model_pen_nseg", expQ.size(), 3);
        checkOutput("model_pen_no_end_110_60", cnt, 0);
        checkOutput("model_pen_seg1_x0", expQ[1].x0, 110);
        applyStimulus(0, 100, 50, 0);
        waitDone(200, 1'b0);
        checkOutput("pen_xfers", xferCnt, 3);
        checkOutput("pen_busy_cycles", busyCnt, 24);

        // Coordinate wrap at the positive limit
        clearRom();
        setVtx(0, 0, 0, 1'b0, 1'b0);
        setVtx(1, 10, 0, 1'b1, 1'b1);
        buildExpected(0, (1 << (DATA_W-1)) - 5, 0);
        checkOutput("model_wrap_x0", expQ[0].x0, 131067);
        checkOutput("model_wrap_x1", expQ[0].x1, -131067);
        applyStimulus(0, (1 << (DATA_W-1)) - 5, 0, 37);
        checkOutput("theta_latched", int'(rot_theta), 37);
        waitDone(100, 1'b0);
        checkOutput("wrap_xfers", xferCnt, 1);
        checkOutput("wrap_busy_cycles", busyCnt, 10);

        // Reset during EMIT, then redraw
        loadSquare();
        buildExpected(0, 100, 50);
        applyStimulus(0, 100, 50, 0);
        waitSegValid(40);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_seg_valid", int'(seg_valid), 0);
        checkOutput("arst_busy", int'(busy), 0);
        expQ.delete();
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        checkOutput("arst_no_done", doneCnt, 0);
        checkOutput("arst_idle_busy", int'(busy), 0);
        buildExpected(0, 100, 50);
        applyStimulus(0, 100, 50, 0);
        waitDone(200, 1'b0);
        checkOutput("redraw_xfers", xferCnt, 4);
        checkOutput("redraw_busy_cycles", busyCnt, 25);

        // No end flag: runaway guard after 16 vertices, stray starts ignored
        for (int i = 0; i < ROM_N; i++) setVtx(i, i, -i, 1'b1, 1'b0);
        buildExpected(3, -20, 7);
        checkOutput("model_run_nseg", expQ.size(), 15);
        checkOutput("model_run_seg0_x0", expQ[0].x0, -17);
        checkOutput("model_run_seg0_x1", expQ[0].x1, -16);
        applyStimulus(3, -20, 7, 0);
        waitDone(400, 1'b1);
        checkOutput("run_xfers", xferCnt, 15);
        checkOutput("run_busy_cycles", busyCnt, 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule
